// File: rtl/pe_pkg.sv
// Shared constants and types for the output-stationary processing element.
// The typedefs describe the default DATA_WIDTH/BUS_WIDTH configuration.
package pe_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned BUS_WIDTH_DEF  = 32;

  typedef logic [DATA_WIDTH_DEF-1:0]   operand_t;
  typedef logic [2*DATA_WIDTH_DEF-1:0] product_t;
  typedef logic [BUS_WIDTH_DEF-1:0]    accum_t;

endpackage : pe_pkg

// File: rtl/pe_mac.sv
// Combinational multiply-add for the PE: next accumulator value from operands and current sum.
// Optional feature macro: PE_SATURATE_EN (clamp at all-ones instead of wrapping).
module pe_mac #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUS_WIDTH  = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [BUS_WIDTH-1:0]  accum,
  input  logic                  load,
  output logic [BUS_WIDTH-1:0]  accum_next
);

  logic [2*DATA_WIDTH-1:0] product_s;
  logic [BUS_WIDTH-1:0]    product_ext_s;

  assign product_s     = a * b;
  assign product_ext_s = BUS_WIDTH'(product_s);

`ifdef PE_SATURATE_EN
  // One extra bit captures the carry out so overflow can be clamped.
  logic [BUS_WIDTH:0] sum_s;

  assign sum_s = {1'b0, accum} + {1'b0, product_ext_s};

  // Select restart load, clamped sum, or plain sum.
  always_comb begin
    accum_next = sum_s[BUS_WIDTH-1:0];
    if (load) begin
      accum_next = product_ext_s;
    end else if (sum_s[BUS_WIDTH]) begin
      accum_next = {BUS_WIDTH{1'b1}};
    end else begin
      accum_next = sum_s[BUS_WIDTH-1:0];
    end
  end
`else
  logic [BUS_WIDTH-1:0] sum_s;

  assign sum_s = accum + product_ext_s;

  // Select restart load or the wrapping sum.
  always_comb begin
    accum_next = sum_s;
    if (load) begin
      accum_next = product_ext_s;
    end else begin
      accum_next = sum_s;
    end
  end
`endif

endmodule : pe_mac

// File: rtl/pe.sv
// Output-stationary systolic processing element: accumulates A*B and forwards operands east/south.
// Optional feature macro: PE_SATURATE_EN (saturating accumulator, implemented in pe_mac).
module pe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BUS_WIDTH  = BUS_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_operation_i,
  input  logic [DATA_WIDTH-1:0] data_A_i,
  input  logic [DATA_WIDTH-1:0] data_B_i,
  output logic [BUS_WIDTH-1:0]  accum_o,
  output logic [DATA_WIDTH-1:0] data_A_o,
  output logic [DATA_WIDTH-1:0] data_B_o
);

  if (BUS_WIDTH < 2 * DATA_WIDTH) begin : g_bad_width
    $error("pe: BUS_WIDTH must be at least 2*DATA_WIDTH");
  end

  logic [BUS_WIDTH-1:0]  accum_r;
  logic [BUS_WIDTH-1:0]  accum_next_s;
  logic [DATA_WIDTH-1:0] data_a_r;
  logic [DATA_WIDTH-1:0] data_b_r;
  logic                  active_r;
  logic                  load_s;

  // A start cycle that was not preceded by one begins a fresh sum.
  assign load_s = ~active_r;

  pe_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_mac (
    .a         (data_A_i),
    .b         (data_B_i),
    .accum     (accum_r),
    .load      (load_s),
    .accum_next(accum_next_s)
  );

  // Accumulator, start-edge flag and operand forwarding registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      accum_r  <= {BUS_WIDTH{1'b0}};
      data_a_r <= {DATA_WIDTH{1'b0}};
      data_b_r <= {DATA_WIDTH{1'b0}};
      active_r <= 1'b0;
    end else begin
      data_a_r <= data_A_i;
      data_b_r <= data_B_i;
      if (start_operation_i) begin
        accum_r  <= accum_next_s;
        active_r <= 1'b1;
      end else begin
        active_r <= 1'b0;
      end
    end
  end

  assign accum_o  = accum_r;
  assign data_A_o = data_a_r;
  assign data_B_o = data_b_r;

endmodule : pe

// File: tb/tb_pe.sv
// Scoreboard bench for pe: the driver queues expected outputs, a monitor compares after each edge.
// A second instance (BUS_WIDTH=16) exercises overflow wrap or PE_SATURATE_EN clamping.
module tb_pe;

  logic        clk = 1'b0;
  logic        rst, start, start16;
  logic [7:0]  a, b, a16, b16;
  logic [31:0] acc_o;
  logic [7:0]  a_o, b_o;
  logic [15:0] acc16_o;
  logic [7:0]  a16_o, b16_o;

  always #5 clk = ~clk;

  pe dut (
    .clk_i(clk), .rst_i(rst), .start_operation_i(start),
    .data_A_i(a), .data_B_i(b),
    .accum_o(acc_o), .data_A_o(a_o), .data_B_o(b_o)
  );

  pe #(.DATA_WIDTH(8), .BUS_WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_operation_i(start16),
    .data_A_i(a16), .data_B_i(b16),
    .accum_o(acc16_o), .data_A_o(a16_o), .data_B_o(b16_o)
  );

  typedef struct {
    string       name;
    bit          chk_acc;
    logic [31:0] acc;
    bit          chk_fwd;
    logic [7:0]  ea;
    logic [7:0]  eb;
    bit          chk16;
    logic [15:0] acc16;
    logic [7:0]  ea16;
    logic [7:0]  eb16;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic exp_t mk(input string n, input bit ca, input logic [31:0] acc,
                              input bit cf, input logic [7:0] ea, input logic [7:0] eb);
    exp_t e;
    e.name = n; e.chk_acc = ca; e.acc = acc; e.chk_fwd = cf; e.ea = ea; e.eb = eb;
    e.chk16 = 1'b0; e.acc16 = 16'd0; e.ea16 = 8'd0; e.eb16 = 8'd0;
    return e;
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle of stimulus on the falling edge and queue what must appear after the next rising edge.
  task automatic step(input bit r, input bit s, input logic [7:0] ia, input logic [7:0] ib,
                      input bit s16, input logic [7:0] ia16, input logic [7:0] ib16, input exp_t e);
    @(negedge clk);
    rst = r; start = s; a = ia; b = ib;
    start16 = s16; a16 = ia16; b16 = ib16;
    q.push_back(e);
  endtask

  // Monitor: one queued expectation is due after every rising edge once stimulus has begun.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk_acc) check({e.name, ".accum"}, acc_o, e.acc);
      if (e.chk_fwd) begin
        check({e.name, ".data_A_o"}, {24'd0, a_o}, {24'd0, e.ea});
        check({e.name, ".data_B_o"}, {24'd0, b_o}, {24'd0, e.eb});
      end
      if (e.chk16) begin
        check({e.name, ".accum16"}, {16'd0, acc16_o}, {16'd0, e.acc16});
        check({e.name, ".data_A_o16"}, {24'd0, a16_o}, {24'd0, e.ea16});
        check({e.name, ".data_B_o16"}, {24'd0, b16_o}, {24'd0, e.eb16});
      end
    end
  end

  initial begin
    exp_t e;
    logic [15:0] exp16_2, exp16_3;
`ifdef PE_SATURATE_EN
    exp16_2 = 16'd65535;
    exp16_3 = 16'd65535;
`else
    exp16_2 = 16'd64514;
    exp16_3 = 16'd64003;
`endif

    // Reset state, with non-zero inputs present to show reset dominates.
    step(1'b1, 1'b1, 8'd9, 8'd9, 1'b1, 8'd3, 8'd3, mk("rst0", 1'b1, 32'd0, 1'b1, 8'd0, 8'd0));
    e = mk("rst1", 1'b1, 32'd0, 1'b1, 8'd0, 8'd0); e.chk16 = 1'b1;
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, e);

    // Accumulate 0*0, 7*3, 2*1, 0*0.
    step(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, mk("acc_0x0", 1'b1, 32'd0,  1'b1, 8'd0, 8'd0));
    step(1'b0, 1'b1, 8'd7, 8'd3, 1'b0, 8'd0, 8'd0, mk("acc_7x3", 1'b1, 32'd21, 1'b1, 8'd7, 8'd3));
    step(1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 8'd0, 8'd0, mk("acc_2x1", 1'b1, 32'd23, 1'b1, 8'd2, 8'd1));
    step(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, mk("acc_0x0b", 1'b1, 32'd23, 1'b1, 8'd0, 8'd0));

    // Idle: forwarding continues, accumulator holds for 50 cycles.
    step(1'b0, 1'b0, 8'd5, 8'd9, 1'b0, 8'd0, 8'd0, mk("fwd_5_9", 1'b1, 32'd23, 1'b1, 8'd5, 8'd9));
    for (int i = 1; i < 50; i++) begin
      step(1'b0, 1'b0, 8'(i * 3), 8'(200 - i), 1'b0, 8'd0, 8'd0,
           mk("hold", 1'b1, 32'd23, 1'b1, 8'(i * 3), 8'(200 - i)));
    end

    // Restart discards 23, then accumulates again.
    step(1'b0, 1'b1, 8'd4, 8'd4, 1'b0, 8'd0, 8'd0, mk("restart_4x4", 1'b1, 32'd16, 1'b1, 8'd4, 8'd4));
    step(1'b0, 1'b1, 8'd3, 8'd5, 1'b0, 8'd0, 8'd0, mk("acc_3x5",     1'b1, 32'd31, 1'b1, 8'd3, 8'd5));

    // Rebuild 23, then reset mid-operation; first start after reset loads.
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, mk("gap",       1'b1, 32'd31, 1'b1, 8'd0, 8'd0));
    step(1'b0, 1'b1, 8'd7, 8'd3, 1'b0, 8'd0, 8'd0, mk("re_7x3",    1'b1, 32'd21, 1'b1, 8'd7, 8'd3));
    step(1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 8'd0, 8'd0, mk("re_2x1",    1'b1, 32'd23, 1'b1, 8'd2, 8'd1));
    step(1'b1, 1'b1, 8'd9, 8'd9, 1'b0, 8'd0, 8'd0, mk("mid_rst",   1'b1, 32'd0,  1'b1, 8'd0, 8'd0));
    step(1'b0, 1'b1, 8'd6, 8'd5, 1'b0, 8'd0, 8'd0, mk("post_rst",  1'b1, 32'd30, 1'b1, 8'd6, 8'd5));
    step(1'b0, 1'b1, 8'd1, 8'd1, 1'b0, 8'd0, 8'd0, mk("post_acc",  1'b1, 32'd31, 1'b1, 8'd1, 8'd1));

    // 16-bit accumulator: 255*255 repeatedly, then hold.
    e = mk("ovf1", 1'b1, 32'd31, 1'b0, 8'd0, 8'd0);
    e.chk16 = 1'b1; e.acc16 = 16'd65025; e.ea16 = 8'd255; e.eb16 = 8'd255;
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd255, 8'd255, e);
    e.name = "ovf2"; e.acc16 = exp16_2;
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd255, 8'd255, e);
    e.name = "ovf3"; e.acc16 = exp16_3;
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd255, 8'd255, e);
    e.name = "ovf_hold"; e.ea16 = 8'd1; e.eb16 = 8'd2;
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd1, 8'd2, e);

    // Let the monitor drain, bounded to a few cycles.
    repeat (3) @(posedge clk);
    #2;
    n_total++;
    if (q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pe

// File: doc/pe.md
PE -- requirements
Module: pe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, width of the unsigned operands A and B.
REQ-002 The block SHALL have parameter BUS_WIDTH, default 32, width of the accumulator.
REQ-003 The block SHALL have clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have start_operation_i, input, 1 bit: accumulate enable.
REQ-006 The block SHALL have data_A_i, input, DATA_WIDTH bits: operand A from the west neighbour.
REQ-007 The block SHALL have data_B_i, input, DATA_WIDTH bits: operand B from the north neighbour.
REQ-008 The block SHALL have accum_o, output, BUS_WIDTH bits: registered accumulated sum of products.
REQ-009 The block SHALL have data_A_o, output, DATA_WIDTH bits: registered copy of data_A_i, toward the east neighbour.
REQ-010 The block SHALL have data_B_o, output, DATA_WIDTH bits: registered copy of data_B_i, toward the south neighbour.

Function
REQ-011 The block SHALL be output-stationary: on every edge where start_operation_i=1, accum <= accum + data_A_i*data_B_i.
REQ-012 The block SHALL treat operands as unsigned, form a 2*DATA_WIDTH-bit product, and zero-extend it to BUS_WIDTH before adding.
REQ-013 The block SHALL make each product visible on accum_o exactly 1 cycle after the edge that samples the operands.
REQ-014 The block SHALL hold accum_o unchanged while start_operation_i=0.
REQ-015 On the first edge where start_operation_i=1 after it was 0 (or after reset), the block SHALL load accum <= data_A_i*data_B_i, discarding the previous sum.
REQ-016 The block SHALL register data_A_i to data_A_o and data_B_i to data_B_o every cycle, independent of start_operation_i (1-cycle forwarding latency).
REQ-017 Without saturation (see REQ-022), the block SHALL wrap accumulator overflow modulo 2^BUS_WIDTH.
REQ-018 The block SHALL require BUS_WIDTH >= 2*DATA_WIDTH, checked at elaboration.

Reset
REQ-019 When rst_i=1 at an edge, the block SHALL clear accum_o, data_A_o and data_B_o to 0 and clear the start-edge tracking flag.
REQ-020 Reset SHALL take priority over start_operation_i, including mid-operation.
REQ-021 After reset, the first cycle with start_operation_i=1 SHALL behave as the start edge of REQ-015.

Configuration
REQ-022 When PE_SATURATE_EN is defined, the block SHALL clamp the accumulator at 2^BUS_WIDTH-1 instead of wrapping, and the clamped value SHALL hold under further accumulation; when it is undefined, the block SHALL wrap per REQ-017.

Structure
REQ-023 A package pe_pkg SHALL hold the default DATA_WIDTH and BUS_WIDTH constants and the operand, product and accumulator typedefs.
REQ-024 The multiply-add (including the optional saturation) SHALL live in one sub-module, pe_mac; the pe module SHALL hold the registers and start-edge logic.

Verification
REQ-025 Reset, then start=1 with A=0, B=0 for 1 cycle; then A=7, B=3; then A=2, B=1; then A=0, B=0; then start=0 -> accum_o reads 21, then 23, and holds 23 for 50 further cycles.
REQ-026 With start=0, drive A=5, B=9 -> data_A_o=5 and data_B_o=9 one cycle later, and accum_o does not change.
REQ-027 After accum_o=23, drop start for 2 cycles, then raise start with A=4, B=4 -> accum_o=16 (restart, no carry-over).
REQ-028 With start=1 and accum_o=23, assert rst_i for 1 cycle -> accum_o=0, data_A_o=0 and data_B_o=0 at the next edge.
REQ-029 With DATA_WIDTH=8 and BUS_WIDTH=16, apply A=255, B=255 for 2 cycles -> accum_o=65025, then 64514 (wrap) without PE_SATURATE_EN, or 65535 with it.
